tile_buf_sched: RTL and testbench
=================================

TILE_BUF_SCHED -- requirements
Module: tile_buf_sched

Interface
REQ-001 Parameter SHALL be: DEPTH, 16, words per tile per bank (power of two, >=2).
REQ-002 Parameter SHALL be: AW, $clog2(DEPTH), write-address width.
REQ-003 Parameter SHALL be: CW, 16, completed-tile counter width.
REQ-004 Port SHALL be: clk  input  1  clock, rising edge.
REQ-005 Port SHALL be: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port SHALL be: ld_valid  input  1  external loader offers one word.
REQ-007 Port SHALL be: ld_ready  output  1  scheduler can accept a word.
REQ-008 Port SHALL be: wr_en  output  1  write strobe to the selected bank.
REQ-009 Port SHALL be: wr_bank  output  1  bank being filled (0=A, 1=B).
REQ-010 Port SHALL be: wr_addr  output  AW  word address within wr_bank.
REQ-011 Port SHALL be: cmp_start  output  1  one-cycle pulse telling the PE array to start.
REQ-012 Port SHALL be: cmp_bank  output  1  bank the PE array reads.
REQ-013 Port SHALL be: cmp_busy  output  1  compute in progress.
REQ-014 Port SHALL be: cmp_done  input  1  PE array finished the current tile (pulse).
REQ-015 Port SHALL be: bank_full  output  2  per-bank FULL flag, bit0=A.
REQ-016 Port SHALL be: tiles_done  output  CW  count of completed tiles.

Function
REQ-017 Each bank SHALL hold a registered state: EMPTY, FULL or BUSY (being read by compute).
REQ-018 ld_ready SHALL equal (state of bank wb == EMPTY), where wb is the registered write-bank pointer; wr_bank = wb.
REQ-019 wr_en SHALL equal ld_valid & ld_ready, combinationally; wr_addr SHALL be the registered fill counter.
REQ-020 On each accepted word the fill counter SHALL increment; on acceptance at DEPTH-1 it SHALL wrap to 0, bank wb SHALL become FULL and wb SHALL toggle, all on the same edge.
REQ-021 Compute FSM SHALL have states C_IDLE, C_START, C_RUN; rb is the registered read-bank pointer, cmp_bank = rb.
REQ-022 C_IDLE -> C_START when bank rb is FULL; C_START -> C_RUN unconditionally, marking bank rb BUSY.
REQ-023 cmp_start SHALL be 1 only in C_START; cmp_busy SHALL be 1 in C_START and C_RUN.
REQ-024 Latency: last word accepted at edge t -> bank_full set after t -> cmp_start high during cycle t+2.
REQ-025 C_RUN -> C_IDLE on cmp_done: bank rb becomes EMPTY, rb toggles, tiles_done increments (wraps at 2^CW).
REQ-026 cmp_done in C_IDLE or C_START SHALL be ignored.
REQ-027 Simultaneous fill-complete of one bank and cmp_done on the other SHALL both take effect on the same edge.
REQ-028 A bank freed by cmp_done SHALL present ld_ready no earlier than the following cycle (registered state).
REQ-029 When both banks are FULL/BUSY, ld_ready SHALL be 0 and the fill counter SHALL hold.
REQ-030 bank_full[i] SHALL be 1 iff bank i state is FULL.

Reset
REQ-031 On rst: both banks EMPTY, wb=0, rb=0, fill counter 0, FSM C_IDLE, tiles_done 0.
REQ-032 Reset outputs: ld_ready=1, wr_en=0 unless ld_valid, wr_bank=0, wr_addr=0, cmp_start=0, cmp_bank=0, cmp_busy=0, bank_full=0.
REQ-033 rst asserted mid-fill or mid-compute SHALL discard all progress; no cmp_start after deassertion until a full tile is reloaded.

Structure
REQ-034 Package tpu_buf_pkg SHALL hold the bank-state enum (EMPTY/FULL/BUSY) and compute-FSM enum (C_IDLE/C_START/C_RUN).
REQ-035 The fill counter with wrap/terminal-count output SHALL be sub-module tile_fill_counter; all else in tile_buf_sched.

Verification (DEPTH=4)
REQ-036 ld_valid held 1 from reset -> wr_addr 0,1,2,3 on bank 0, then 0..3 on bank 1, then ld_ready=0; cmp_start high exactly once, 2 cycles after word 3.
REQ-037 cmp_done pulsed 5 cycles after cmp_start -> bank 0 EMPTY, cmp_bank=1, ld_ready=1 next cycle, tiles_done=1, second cmp_start follows.
REQ-038 Last word of bank 1 accepted same edge as cmp_done for bank 0 -> bank_full=2'b10, bank 0 EMPTY, tiles_done=1, no lost state.
REQ-039 cmp_done pulsed in C_IDLE -> no state change, tiles_done stays 0.
REQ-040 rst asserted after 2 words and during C_RUN -> all outputs at reset values; next cmp_start only after 4 new words.

Source files
------------

// File: rtl/tpu_buf_pkg.sv
// Shared types for the double-buffered tile scheduler: the bank occupancy state and
// the states of the compute handshake FSM.
package tpu_buf_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      BUSY  = 2'd2
   } bank_st_e;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_START = 2'd1,
      C_RUN   = 2'd2
   } cmp_st_e;

   localparam int unsigned NUM_BANKS = 2;

endpackage

// File: rtl/tile_fill_counter.sv
// Word address counter for the bank being filled. It wraps after DEPTH accepted words
// and flags that final word so the scheduler can close the bank on the same edge.
module tile_fill_counter #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [AW-1:0] cnt,
   output logic          tc
);

   logic [AW-1:0] cnt_q;

   assign cnt = cnt_q;
   assign tc  = inc && (cnt_q == AW'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= tc ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/tile_buf_sched.sv
// Ping-pong tile buffer scheduler: the loader fills one bank while the PE array
// computes from the other; each bank cycles EMPTY -> FULL -> BUSY -> EMPTY.
module tile_buf_sched
   import tpu_buf_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_valid,
   output logic          ld_ready,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic          cmp_start,
   output logic          cmp_bank,
   output logic          cmp_busy,
   input  logic          cmp_done,
   output logic [1:0]    bank_full,
   output logic [CW-1:0] tiles_done
);

   bank_st_e      bank_q [NUM_BANKS];
   logic          wb_q;
   logic          rb_q;
   cmp_st_e       cst_q;
   logic [CW-1:0] tiles_q;
   logic          cmp_start_q;
   logic          cmp_busy_q;
   logic          fill_done;

   assign ld_ready   = (bank_q[wb_q] == EMPTY);
   assign wr_en      = ld_valid & ld_ready;
   assign wr_bank    = wb_q;
   assign cmp_bank   = rb_q;
   assign cmp_start  = cmp_start_q;
   assign cmp_busy   = cmp_busy_q;
   assign tiles_done = tiles_q;
   assign bank_full  = {bank_q[1] == FULL, bank_q[0] == FULL};

   tile_fill_counter #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fill (
      .clk (clk),
      .rst (rst),
      .inc (wr_en),
      .cnt (wr_addr),
      .tc  (fill_done)
   );

   // A filling bank is always EMPTY while the compute side only touches FULL/BUSY
   // banks, so fill and compute updates never target the same bank on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q[0]   <= EMPTY;
         bank_q[1]   <= EMPTY;
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         cst_q       <= C_IDLE;
         tiles_q     <= '0;
         cmp_start_q <= 1'b0;
         cmp_busy_q  <= 1'b0;
      end else begin
         cmp_start_q <= 1'b0;
         if (fill_done) begin
            bank_q[wb_q] <= FULL;
            wb_q         <= ~wb_q;
         end
         unique case (cst_q)
            C_IDLE: begin
               if (bank_q[rb_q] == FULL) begin
                  cst_q       <= C_START;
                  cmp_start_q <= 1'b1;
                  cmp_busy_q  <= 1'b1;
               end
            end
            C_START: begin
               bank_q[rb_q] <= BUSY;
               cst_q        <= C_RUN;
            end
            C_RUN: begin
               if (cmp_done) begin
                  bank_q[rb_q] <= EMPTY;
                  rb_q         <= ~rb_q;
                  tiles_q      <= tiles_q + 1'b1;
                  cst_q        <= C_IDLE;
                  cmp_busy_q   <= 1'b0;
               end
            end
            default: begin
               cst_q      <= C_IDLE;
               cmp_busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_buf_sched.sv
// Scoreboard bench for tile_buf_sched at DEPTH=4: directed stimulus queues the expected
// writes and compute starts, and a negedge monitor checks them as the DUT emits them.
module tb_tile_buf_sched;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ld_valid = 1'b0;
   logic          cmp_done = 1'b0;
   logic          ld_ready;
   logic          wr_en;
   logic          wr_bank;
   logic [AW-1:0] wr_addr;
   logic          cmp_start;
   logic          cmp_bank;
   logic          cmp_busy;
   logic [1:0]    bank_full;
   logic [CW-1:0] tiles_done;

   typedef struct {
      logic          bank;
      logic [CW-1:0] tiles;
      int            at;
   } start_t;

   logic [AW:0] wq [$];
   start_t      sq [$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          base;
   logic [AW:0] mon_w;
   start_t      mon_s;

   tile_buf_sched #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .wr_en      (wr_en),
      .wr_bank    (wr_bank),
      .wr_addr    (wr_addr),
      .cmp_start  (cmp_start),
      .cmp_bank   (cmp_bank),
      .cmp_busy   (cmp_busy),
      .cmp_done   (cmp_done),
      .bank_full  (bank_full),
      .tiles_done (tiles_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic b, input int a);
      wq.push_back({b, AW'(a)});
   endtask

   task automatic push_start(input logic b, input int t, input int at);
      start_t s;
      s.bank  = b;
      s.tiles = CW'(t);
      s.at    = at;
      sq.push_back(s);
   endtask

   task automatic check_reset();
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_bank", 32'(wr_bank), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_cmp_start", 32'(cmp_start), 32'd0);
      chk("rst_cmp_bank", 32'(cmp_bank), 32'd0);
      chk("rst_cmp_busy", 32'(cmp_busy), 32'd0);
      chk("rst_bank_full", 32'(bank_full), 32'd0);
      chk("rst_tiles_done", 32'(tiles_done), 32'd0);
   endtask

   // Monitor: every write strobe and every compute start must match the next queued entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected actual=bank%0d/addr%0d required=no write (cycle %0d)",
                        wr_bank, wr_addr, cyc);
            end else begin
               checks--;
               mon_w = wq.pop_front();
               chk("wr_bank_addr", 32'({wr_bank, wr_addr}), 32'(mon_w));
            end
         end
         if (cmp_start) begin
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL start_unexpected actual=cmp_start required=no start (cycle %0d)",
                        cyc);
            end else begin
               checks--;
               mon_s = sq.pop_front();
               chk("start_bank", 32'(cmp_bank), 32'(mon_s.bank));
               chk("start_tiles", 32'(tiles_done), 32'(mon_s.tiles));
               chk("start_cycle", 32'(cyc), 32'(mon_s.at));
            end
         end
      end
   end

   initial begin
      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset();
      tick();
      rst = 1'b0;

      // Continuous load into both banks, start ignoring an early cmp_done, then hand-off.
      base     = cyc;
      ld_valid = 1'b1;
      for (int i = 0; i < 4; i++) push_wr(1'b0, i);
      for (int i = 0; i < 4; i++) push_wr(1'b1, i);
      push_start(1'b0, 0, base + 5);
      for (int e = 1; e <= 14; e++) begin
         tick();
         case (e)
            5: cmp_done = 1'b1;
            6: begin
               cmp_done = 1'b0;
               @(negedge clk);
               chk("start_state_busy", 32'(cmp_busy), 32'd1);
               chk("start_state_tiles", 32'(tiles_done), 32'd0);
               chk("start_state_full", 32'(bank_full), 32'd0);
            end
            8: begin
               @(negedge clk);
               chk("both_used_ready", 32'(ld_ready), 32'd0);
               chk("both_used_full", 32'(bank_full), 32'b10);
               chk("both_used_wbank", 32'(wr_bank), 32'd0);
            end
            9: begin
               ld_valid = 1'b0;
               @(negedge clk);
               chk("stall_addr", 32'(wr_addr), 32'd0);
               chk("stall_ready", 32'(ld_ready), 32'd0);
            end
            10: cmp_done = 1'b1;
            11: begin
               cmp_done = 1'b0;
               @(negedge clk);
               chk("freed_ready", 32'(ld_ready), 32'd1);
               chk("freed_tiles", 32'(tiles_done), 32'd1);
               chk("freed_cmp_bank", 32'(cmp_bank), 32'd1);
               chk("freed_full", 32'(bank_full), 32'b10);
               chk("freed_busy", 32'(cmp_busy), 32'd0);
               push_start(1'b1, 1, base + 12);
            end
            12: begin
               ld_valid = 1'b1;
               push_wr(1'b0, 0);
               push_wr(1'b0, 1);
            end
            14: ld_valid = 1'b0;
            default: ;
         endcase
      end

      // Reset after two words and while computing discards everything.
      rst = 1'b1;
      @(negedge clk);
      check_reset();
      tick();
      rst = 1'b0;

      // cmp_done while idle is ignored.
      tick();
      cmp_done = 1'b1;
      tick();
      cmp_done = 1'b0;
      @(negedge clk);
      chk("idle_done_tiles", 32'(tiles_done), 32'd0);
      chk("idle_done_busy", 32'(cmp_busy), 32'd0);
      chk("idle_done_full", 32'(bank_full), 32'd0);
      chk("idle_done_ready", 32'(ld_ready), 32'd1);
      repeat (3) tick();

      // Three words, pause, then the fourth: start follows only the fourth.
      base     = cyc;
      ld_valid = 1'b1;
      for (int i = 0; i < 3; i++) push_wr(1'b0, i);
      repeat (3) tick();
      ld_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("partial_full", 32'(bank_full), 32'd0);
      chk("partial_busy", 32'(cmp_busy), 32'd0);
      chk("partial_addr", 32'(wr_addr), 32'd3);
      ld_valid = 1'b1;
      push_wr(1'b0, 3);
      push_start(1'b0, 0, base + 8);
      tick();
      ld_valid = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("reload_busy", 32'(cmp_busy), 32'd1);
      chk("reload_full", 32'(bank_full), 32'd0);
      chk("reload_ready", 32'(ld_ready), 32'd1);
      chk("reload_wbank", 32'(wr_bank), 32'd1);

      // Fill-complete of bank 1 on the same edge as cmp_done for bank 0.
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      base     = cyc;
      ld_valid = 1'b1;
      for (int i = 0; i < 4; i++) push_wr(1'b0, i);
      for (int i = 0; i < 4; i++) push_wr(1'b1, i);
      push_start(1'b0, 0, base + 5);
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 7) cmp_done = 1'b1;
      end
      cmp_done = 1'b0;
      ld_valid = 1'b0;
      push_start(1'b1, 1, base + 9);
      @(negedge clk);
      chk("coll_full", 32'(bank_full), 32'b10);
      chk("coll_tiles", 32'(tiles_done), 32'd1);
      chk("coll_ready", 32'(ld_ready), 32'd1);
      chk("coll_cmp_bank", 32'(cmp_bank), 32'd1);
      chk("coll_wbank", 32'(wr_bank), 32'd0);
      chk("coll_addr", 32'(wr_addr), 32'd0);
      repeat (2) tick();
      @(negedge clk);
      chk("coll_run_full", 32'(bank_full), 32'd0);
      chk("coll_run_busy", 32'(cmp_busy), 32'd1);
      cmp_done = 1'b1;
      tick();
      cmp_done = 1'b0;
      @(negedge clk);
      chk("second_done_tiles", 32'(tiles_done), 32'd2);
      chk("second_done_busy", 32'(cmp_busy), 32'd0);
      chk("second_done_bank", 32'(cmp_bank), 32'd0);
      chk("second_done_full", 32'(bank_full), 32'd0);

      repeat (3) tick();
      @(negedge clk);
      chk("wr_queue_drained", 32'(wq.size()), 32'd0);
      chk("start_queue_drained", 32'(sq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
